// File: rtl/raycast_pkg.sv
// Shared constants for the raycast frame pipeline: screen geometry, palette,
// timeout default and the column-sequencer state encoding.
package raycast_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int TIMEOUT_DEF  = 1023;

  localparam logic [2:0] CEIL_COLOUR_DEF  = 3'b001;
  localparam logic [2:0] WALL_COLOUR_DEF  = 3'b100;
  localparam logic [2:0] FLOOR_COLOUR_DEF = 3'b010;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_BOUNDS = 3'd4;
  localparam logic [2:0] ST_DRAW   = 3'd5;
  localparam logic [2:0] ST_NEXT   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

endpackage

// File: rtl/column_painter.sv
// Paints one screen column top to bottom: ceiling, centred wall slice, floor.
// A start pulse latches the wall bounds; done pulses alongside the last row.
module column_painter
  import raycast_pkg::*;
#(
  parameter int         SCREEN_H     = SCREEN_H_DEF,
  parameter logic [2:0] CEIL_COLOUR  = CEIL_COLOUR_DEF,
  parameter logic [2:0] WALL_COLOUR  = WALL_COLOUR_DEF,
  parameter logic [2:0] FLOOR_COLOUR = FLOOR_COLOUR_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] hc,
  output logic       plot,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       done
);

  localparam logic [7:0] H8     = 8'(SCREEN_H);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  logic       active_q, active_d;
  logic [6:0] y_q, y_d;
  logic [7:0] top_q, top_d;
  logic [7:0] wend_q, wend_d;
  logic [7:0] top_new;

  // hc is already clamped to SCREEN_H, so none of this can wrap
  assign top_new = (H8 - hc) >> 1;

  always_comb begin
    active_d = active_q;
    y_d      = y_q;
    top_d    = top_q;
    wend_d   = wend_q;
    done     = 1'b0;
    if (start) begin
      active_d = 1'b1;
      y_d      = '0;
      top_d    = top_new;
      wend_d   = top_new + hc;
    end else if (active_q) begin
      if (y_q == Y_LAST) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        y_d = y_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      active_q <= 1'b0;
      y_q      <= '0;
      top_q    <= '0;
      wend_q   <= '0;
    end else begin
      active_q <= active_d;
      y_q      <= y_d;
      top_q    <= top_d;
      wend_q   <= wend_d;
    end
  end

  always_comb begin
    plot       = active_q;
    vga_y      = '0;
    vga_colour = '0;
    if (active_q) begin
      vga_y = y_q;
      if ({1'b0, y_q} < top_q)       vga_colour = CEIL_COLOUR;
      else if ({1'b0, y_q} < wend_q) vga_colour = WALL_COLOUR;
      else                           vga_colour = FLOOR_COLOUR;
    end
  end

endmodule

// File: rtl/frame_column_sequencer.sv
// Steps a frame across all screen columns, fetching one slice height per column
// from the slice calculator and handing it to the column painter.
module frame_column_sequencer
  import raycast_pkg::*;
#(
  parameter int         SCREEN_W     = SCREEN_W_DEF,
  parameter int         SCREEN_H     = SCREEN_H_DEF,
  parameter logic [2:0] CEIL_COLOUR  = CEIL_COLOUR_DEF,
  parameter logic [2:0] WALL_COLOUR  = WALL_COLOUR_DEF,
  parameter logic [2:0] FLOOR_COLOUR = FLOOR_COLOUR_DEF,
  parameter int         TIMEOUT      = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_frame,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] column_count,
  output logic       begin_calc,
  input  logic       end_calc,
  input  logic [6:0] slice_size,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic [2:0] dbg_state
);

  // Handshake: begin_calc pulses for the single REQ cycle; end_calc is only
  // sampled in WAIT, its first high cycle wins, and slice_size is taken one
  // cycle later in LATCH.
  localparam logic [7:0] COL_LAST = 8'(SCREEN_W - 1);
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [7:0] H8       = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] col_q, col_d;
  logic       busy_q, busy_d;
  logic [9:0] to_q, to_d;
  logic [6:0] h_q, h_d;
  logic [7:0] hc;
  logic       paint_start, paint_done, paint_plot;

  assign hc = ({1'b0, h_q} > H8) ? H8 : {1'b0, h_q};

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    busy_d      = busy_q;
    to_d        = to_q;
    h_d         = h_q;
    paint_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          state_d = ST_REQ;
          col_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_REQ: begin
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (end_calc) begin
          state_d = ST_LATCH;
        end else begin
          to_d = to_q + 10'd1;
          // a silent calculator yields an empty (h=0) column rather than a stall
          if (to_q == TO_LAST) begin
            h_d     = '0;
            state_d = ST_BOUNDS;
          end
        end
      end
      ST_LATCH: begin
        h_d     = slice_size;
        state_d = ST_BOUNDS;
      end
      ST_BOUNDS: begin
        paint_start = 1'b1;
        state_d     = ST_DRAW;
      end
      ST_DRAW: begin
        if (paint_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (col_q == COL_LAST) begin
          state_d = ST_DONE;
        end else begin
          col_d   = col_q + 8'd1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      h_q     <= h_d;
    end
  end

  column_painter #(
    .SCREEN_H    (SCREEN_H),
    .CEIL_COLOUR (CEIL_COLOUR),
    .WALL_COLOUR (WALL_COLOUR),
    .FLOOR_COLOUR(FLOOR_COLOUR)
  ) u_painter (
    .clock     (clock),
    .resetn    (resetn),
    .start     (paint_start),
    .hc        (hc),
    .plot      (paint_plot),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .done      (paint_done)
  );

  assign plot         = paint_plot;
  assign vga_x        = paint_plot ? col_q : 8'd0;
  assign busy         = busy_q;
  assign column_count = col_q;
  assign begin_calc   = (state_q == ST_REQ);
  assign frame_done   = (state_q == ST_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_frame_column_sequencer.sv
// Directed bench for frame_column_sequencer: stub slice calculator, per-pixel
// capture of the plot stream, and hand-computed column layouts and periods.
module tb_frame_column_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_frame = 1'b0;
  logic       end_calc = 1'b0;
  logic [6:0] slice_size = 7'd0;
  logic       busy, frame_done, begin_calc, plot;
  logic [7:0] column_count, vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour, dbg_state;

  localparam logic [2:0] C_CEIL  = 3'b001;
  localparam logic [2:0] C_WALL  = 3'b100;
  localparam logic [2:0] C_FLOOR = 3'b010;

  frame_column_sequencer dut (
    .clock(clock), .resetn(resetn), .start_frame(start_frame), .busy(busy),
    .frame_done(frame_done), .column_count(column_count), .begin_calc(begin_calc),
    .end_calc(end_calc), .slice_size(slice_size), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [2:0] pix [0:159][0:119];
  int plots_per_col [0:159];
  int bc_time [0:160];
  int bc_cnt, fd_cnt, x_bad;

  // mode 0: stub answers 3 cycles after begin_calc with a per-column height
  // (col 10 never answers); mode 1: end_calc held high, height 40, plus a
  // stray start_frame mid-frame.
  function automatic int answer(input int col);
    if (col == 5) return 0;
    if (col == 6) return 127;
    if (col == 7) return 7;
    if (col == 10) return -1;
    return 40;
  endfunction

  task automatic run_frame(input int mode, input int budget, output int timed_out);
    int countdown, cur, n, after, a;
    bc_cnt = 0; fd_cnt = 0; x_bad = 0; cur = -1; countdown = -1; after = -1;
    for (int c = 0; c < 160; c++) begin
      plots_per_col[c] = 0;
      for (int r = 0; r < 120; r++) pix[c][r] = 3'b111;
    end
    @(negedge clock);
    start_frame = 1'b1;
    end_calc = (mode == 1);
    @(negedge clock);
    start_frame = 1'b0;
    n = 0;
    timed_out = 1;
    while (n < budget) begin
      if (mode == 0) begin
        end_calc = 1'b0;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            end_calc = 1'b1;
            countdown = -1;
          end
        end
      end else begin
        start_frame = (n == 500);
      end
      if (begin_calc) begin
        if (bc_cnt <= 160) bc_time[bc_cnt] = cyc;
        cur = bc_cnt;
        bc_cnt++;
        if (mode == 0) begin
          a = answer(cur);
          end_calc = 1'b0;
          if (a >= 0) begin
            slice_size = 7'(a);
            countdown = 3;
          end else begin
            countdown = -1;
          end
        end else begin
          slice_size = 7'd40;
        end
      end
      if (plot) begin
        if (cur < 0 || cur > 159 || vga_x != 8'(cur) || vga_y > 7'd119) x_bad++;
        else begin
          pix[cur][vga_y] = vga_colour;
          plots_per_col[cur]++;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        if (after < 0) after = 20;
      end
      if (after > 0) after--;
      if (after == 0) begin
        timed_out = 0;
        break;
      end
      @(negedge clock);
      n++;
    end
    start_frame = 1'b0;
    end_calc = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({busy, frame_done, begin_calc, plot} !== 4'b0 || column_count !== 8'd0 ||
        vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b fd=%b bc=%b plot=%b col=%0d x=%0d y=%0d c=%b st=%0d want all 0",
               busy, frame_done, begin_calc, plot, column_count, vga_x, vga_y, vga_colour, dbg_state);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0 || begin_calc !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b bc=%b plot=%b want 0 0 0", busy, begin_calc, plot);
    end
  endtask

  task automatic test_frame();
    int to, nbad;
    int ccol[7]  = '{0, 5, 6, 7, 10, 11, 159};
    int ctop[7]  = '{40, 60, 0, 56, 60, 40, 40};
    int cwend[7] = '{80, 60, 120, 63, 60, 80, 80};
    run_frame(0, 23000, to);
    total++;
    if (to != 0) begin bad++; $display("FAIL frame_timeout got no frame_done within budget want frame_done"); end
    total++;
    if (bc_cnt != 160) begin bad++; $display("FAIL frame_begin_calc_count got %0d want 160", bc_cnt); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    total++;
    if (x_bad != 0) begin bad++; $display("FAIL frame_vga_x got %0d stray plots want 0", x_bad); end
    nbad = 0;
    for (int c = 0; c < 160; c++) if (plots_per_col[c] != 120) nbad++;
    total++;
    if (nbad != 0) begin bad++; $display("FAIL frame_plots_per_col got %0d columns off (col0=%0d) want 120 each", nbad, plots_per_col[0]); end
    total++;
    if (bc_time[1] - bc_time[0] != 127) begin bad++; $display("FAIL col0_period got %0d want 127", bc_time[1] - bc_time[0]); end
    total++;
    if (bc_time[11] - bc_time[10] != 1146) begin bad++; $display("FAIL col10_timeout_period got %0d want 1146", bc_time[11] - bc_time[10]); end
    for (int k = 0; k < 7; k++) begin
      int badrow;
      logic [2:0] e, g;
      badrow = -1; e = 3'b0; g = 3'b0;
      for (int r = 0; r < 120; r++) begin
        logic [2:0] ex;
        ex = (r < ctop[k]) ? C_CEIL : ((r < cwend[k]) ? C_WALL : C_FLOOR);
        if (pix[ccol[k]][r] !== ex && badrow < 0) begin
          badrow = r; e = ex; g = pix[ccol[k]][r];
        end
      end
      total++;
      if (badrow >= 0) begin
        bad++;
        $display("FAIL colour col=%0d row=%0d got %b want %b", ccol[k], badrow, g, e);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_end got %b want 0", busy); end
  endtask

  task automatic test_start_ignored();
    int to, nbad, first;
    run_frame(1, 22000, to);
    total++;
    if (to != 0) begin bad++; $display("FAIL held_timeout got no frame_done within budget want frame_done"); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL held_frame_done_count got %0d want 1", fd_cnt); end
    total++;
    if (bc_cnt != 160) begin bad++; $display("FAIL held_begin_calc_count got %0d want 160", bc_cnt); end
    nbad = 0; first = 0;
    for (int c = 0; c < 159; c++)
      if (bc_time[c + 1] - bc_time[c] != 125) begin
        if (nbad == 0) first = bc_time[c + 1] - bc_time[c];
        nbad++;
      end
    total++;
    if (nbad != 0) begin bad++; $display("FAIL held_period got %0d bad columns (first %0d) want 125 each", nbad, first); end
    total++;
    if (pix[0][39] !== C_CEIL || pix[0][40] !== C_WALL || pix[0][79] !== C_WALL || pix[0][80] !== C_FLOOR) begin
      bad++;
      $display("FAIL held_col0_layout got %b %b %b %b want 001 100 100 010", pix[0][39], pix[0][40], pix[0][79], pix[0][80]);
    end
  endtask

  task automatic test_reset_mid_draw();
    int n, found;
    @(negedge clock);
    start_frame = 1'b1;
    end_calc = 1'b1;
    slice_size = 7'd40;
    @(negedge clock);
    start_frame = 1'b0;
    found = 0;
    for (n = 0; n < 2000; n++) begin
      if (plot && vga_x == 8'd3 && vga_y == 7'd10) begin found = 1; break; end
      @(negedge clock);
    end
    total++;
    if (found == 0) begin bad++; $display("FAIL reach_col3_draw got not reached want col3 row10 plot"); end
    resetn = 1'b0;
    @(negedge clock);
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || column_count !== 8'd0 || begin_calc !== 1'b0 || vga_colour !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset got plot=%b busy=%b col=%0d bc=%b c=%b want 0 0 0 0 0", plot, busy, column_count, begin_calc, vga_colour);
    end
    resetn = 1'b1;
    end_calc = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (plot !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got plot=%b busy=%b want 0 0", plot, busy); end
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
    end_calc = 1'b1;
    total++;
    if (begin_calc !== 1'b1 || column_count !== 8'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_req got bc=%b col=%0d busy=%b want 1 0 1", begin_calc, column_count, busy);
    end
    found = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (plot) begin found = n; break; end
    end
    total++;
    if (found != 4 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== C_CEIL) begin
      bad++;
      $display("FAIL restart_first_pixel got delay=%0d x=%0d y=%0d c=%b want 4 0 0 001", found, vga_x, vga_y, vga_colour);
    end
    resetn = 1'b0;
    end_calc = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_start_ignored();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_column_sequencer.md
Name: frame_column_sequencer

Overview:
- Master side of the slice-height handshake. Steps through screen columns 0..SCREEN_W-1 and requests one slice height per column from find_slice_height (column_count / begin_calc / end_calc / slice_size).
- Paints each column on the VGA adapter as ceiling, centred wall slice, then floor, one pixel per clock.
- Sits between the frame-start controller and the VGA adapter plot port.

Parameters:
SCREEN_W, 160, number of columns; column_count runs 0..SCREEN_W-1
SCREEN_H, 120, number of rows; also the clamp for slice height
CEIL_COLOUR, 3'b001, colour for rows above the wall
WALL_COLOUR, 3'b100, colour for wall rows
FLOOR_COLOUR, 3'b010, colour for rows below the wall
TIMEOUT, 1023, maximum cycles to wait for end_calc before forcing height 0

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
start_frame  in  1  one-cycle request to render a frame; sampled only in IDLE
busy  out  1  high from frame accept until frame_done
frame_done  out  1  one-cycle pulse after last pixel of last column
column_count  out  8  column index presented to slice calculator; stable from REQ through LATCH
begin_calc  out  1  one-cycle pulse per column
end_calc  in  1  slice calculator completion (level or pulse; first high cycle counts)
slice_size  in  7  slice height; valid the cycle after end_calc is first seen high
vga_x  out  8  pixel column (equals column_count during DRAW)
vga_y  out  7  pixel row
vga_colour  out  3  pixel colour
plot  out  1  write strobe; vga_x/vga_y/vga_colour are valid whenever plot=1

Behaviour:
- Reset (resetn=0 at posedge): state IDLE. All outputs 0: busy, frame_done, begin_calc, plot, column_count, vga_x, vga_y, vga_colour. Timeout counter 0. Reset mid-frame aborts immediately; no further plot.
- States and transitions:
  - IDLE: go to REQ on start_frame=1; column_count<=0; busy<=1.
  - REQ: begin_calc=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT: when end_calc=1, go to LATCH. Otherwise increment the timeout counter. If the counter reaches TIMEOUT, use height 0 and go to BOUNDS, skipping LATCH.
  - LATCH: h<=slice_size; go to BOUNDS.
  - BOUNDS: hc=min(h,SCREEN_H); top<=(SCREEN_H-hc)>>1 (floor); wall_end<=top+hc. Clear y counter. Go to DRAW.
  - DRAW: plot=1 every cycle. vga_x=column_count, vga_y=y.
    - Colour: y<top gives CEIL_COLOUR; top<=y<wall_end gives WALL_COLOUR; otherwise FLOOR_COLOUR.
    - y increments 0..SCREEN_H-1; after y=SCREEN_H-1, go to NEXT.
  - NEXT: plot=0. If column_count=SCREEN_W-1, go to DONE. Else column_count++ and go to REQ.
  - DONE: frame_done=1 for one cycle; busy<=0; go to IDLE.
- Latency:
  - Per column: 1(REQ) + w(WAIT, w>=1) + 1(LATCH) + 1(BOUNDS) + SCREEN_H(DRAW) + 1(NEXT).
  - w = cycles until end_calc is seen, counting the cycle it is seen.
- Handshake rules:
  - end_calc high on the same cycle as begin_calc is ignored; only WAIT samples end_calc.
  - end_calc held high across columns is harmless: each column waits at least one WAIT cycle after REQ.
- start_frame during a frame (busy=1) is ignored, not queued.
- Boundaries:
  - h=0 gives top=SCREEN_H/2 and wall_end=top, so no wall rows.
  - h>=SCREEN_H gives a full-height wall.
  - Odd h rounds top down: wall sits one row above centre.
- Widths:
  - All bound arithmetic is unsigned 8-bit; no overflow because hc<=120.
  - The timeout counter is 10 bits.

Decomposition:
- Package raycast_pkg holds:
  - SCREEN_W and SCREEN_H defaults;
  - colour constants;
  - state encoding localparams (IDLE, REQ, WAIT, LATCH, BOUNDS, DRAW, NEXT, DONE; 3 bits).
- One natural sub-module: column_painter. It takes hc and a start pulse, produces the vga_y/vga_colour/plot stream for one column, and returns a done pulse. The sequencer FSM owns the handshake and column stepping.

Test Plan:
- Stub calculator answers with slice_size=40 three cycles after begin_calc, every column. Required for column 0:
  - rows 0..39 CEIL, rows 40..79 WALL, rows 80..119 FLOOR;
  - 120 plots with vga_x=0;
  - column period = 1+3+1+1+120+1 = 127 cycles.
  - Expect 160 begin_calc pulses, then one frame_done.
- slice_size=0 on column 5 and 127 on column 6. Required:
  - column 5: rows 0..59 CEIL, rows 60..119 FLOOR, no WALL;
  - column 6: all 120 rows WALL.
- slice_size=7: top=56, WALL exactly on rows 56..62, FLOOR from row 63.
- Stub never asserts end_calc on column 10. Required:
  - after 1023 WAIT cycles, column 10 is drawn as h=0;
  - column 11 then gets its begin_calc pulse.
- Scenario: assert start_frame mid-frame, then hold end_calc high constantly. Required:
  - start_frame ignored: one frame_done only;
  - exactly one begin_calc per column;
  - each column's WAIT lasts 1 cycle.
- Drive resetn=0 during DRAW of column 3, then release. Required:
  - next cycle plot=0, busy=0, column_count=0;
  - a new start_frame restarts from column 0, row 0.
